// File: rtl/prison_cycle_engine_pkg.sv
// Shared types and default guard keys for the prisoner-game search engine.
package prison_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CHECK  = 3'd1,
        START  = 3'd2,
        SEARCH = 3'd3,
        DONE   = 3'd4
    } state_e;

    typedef enum logic {
        MODE_CYCLE  = 1'b0,
        MODE_LINEAR = 1'b1
    } mode_e;

    localparam logic [31:0] DEF_BOX_KEY  = 32'hDEADBEEF;
    localparam logic [31:0] DEF_PRIS_KEY = 32'hCAFEFACE;

endpackage

// File: rtl/prison_cycle_engine_perm_table.sv
// One permutation table: N slots holding distinct values 1..N, with write
// validation, a used-value bitmap so duplicates are refused, and an async read port.
module prison_perm_table
    import prison_pkg::*;
#(
    parameter int          N     = 100,
    parameter int          IDX_W = $clog2(N + 1),
    parameter logic [31:0] KEY   = DEF_BOX_KEY
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [31:0]      key,
    input  logic [IDX_W-1:0] select,
    input  logic [IDX_W-1:0] data,
    output logic             wr_ok,
    output logic             all_loaded,
    input  logic [IDX_W-1:0] rd_addr,
    output logic [IDX_W-1:0] rd_data
);

    localparam int               DEPTH = 2 ** IDX_W;
    localparam logic [IDX_W-1:0] ONE   = IDX_W'(1);
    localparam logic [IDX_W-1:0] NVAL  = IDX_W'(N);

    logic [IDX_W-1:0] mem_r [DEPTH];
    logic [DEPTH-1:0] loaded_r;
    logic [DEPTH-1:0] used_r;

    logic [IDX_W-1:0] old_val_s;
    logic [IDX_W-1:0] data_m1_s;
    logic [IDX_W-1:0] old_m1_s;
    logic             same_slot_s;
    logic             dup_s;

    // Write validation; a slot may be rewritten with the value it already holds.
    always_comb begin
        old_val_s   = mem_r[select];
        data_m1_s   = data - ONE;
        old_m1_s    = old_val_s - ONE;
        same_slot_s = loaded_r[select] && (old_val_s == data);
        dup_s       = used_r[data_m1_s] && !same_slot_s;
        wr_ok       = (select < NVAL) && (data != {IDX_W{1'b0}}) && (data <= NVAL)
                      && (key == KEY) && !dup_s;
        all_loaded  = &loaded_r[N-1:0];
        rd_data     = mem_r[rd_addr];
    end

    // Loaded/used bitmaps; overwriting a slot releases its previous value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            loaded_r <= {DEPTH{1'b0}};
            used_r   <= {DEPTH{1'b0}};
        end else if (wr_en) begin
            if (loaded_r[select]) begin
                used_r[old_m1_s] <= 1'b0;
            end
            used_r[data_m1_s] <= 1'b1;
            loaded_r[select]  <= 1'b1;
        end
    end

    // Table storage, deliberately not reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_r[select] <= data;
        end
    end

endmodule

// File: rtl/prison_cycle_engine.sv
// Prisoner-game engine: guarded loading of box and prisoner tables, then a
// per-prisoner box search (cycle-following or linear) under a try budget.
module prison_cycle_engine
    import prison_pkg::*;
#(
    parameter int          N         = 100,
    parameter int          MAX_TRIES = N / 2,
    parameter int          IDX_W     = $clog2(N + 1),
    parameter logic [31:0] BOX_KEY   = DEF_BOX_KEY,
    parameter logic [31:0] PRIS_KEY  = DEF_PRIS_KEY
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_boxes,
    input  logic             load_prisoners,
    input  logic [IDX_W-1:0] select,
    input  logic [IDX_W-1:0] data,
    input  logic [31:0]      guard_key,
    input  logic             mode,
    input  logic             run,
    output logic             busy,
    output logic             done,
    output logic             win,
    output logic             load_err,
    output logic [IDX_W-1:0] fail_idx,
    output logic [IDX_W-1:0] max_chain
);

    localparam int               TRY_W     = $clog2(MAX_TRIES + 1);
    localparam int               CW        = (TRY_W > IDX_W) ? TRY_W : IDX_W;
    localparam logic [IDX_W-1:0] ONE       = IDX_W'(1);
    localparam logic [IDX_W-1:0] LAST      = IDX_W'(N - 1);
    localparam logic [IDX_W-1:0] NVAL      = IDX_W'(N);
    localparam logic [IDX_W-1:0] MAX_VAL   = IDX_W'(MAX_TRIES);
    localparam logic [TRY_W-1:0] TRY_ONE   = TRY_W'(1);
    localparam logic [TRY_W-1:0] TRY_LIMIT = TRY_W'(MAX_TRIES);

    state_e           state_r, next_s;
    mode_e            mode_r, mode_n;
    logic [IDX_W-1:0] p_r, p_n, cur_r, cur_n;
    logic [TRY_W-1:0] tries_r, tries_n, tries_inc_s;
    logic             win_r, win_n, done_r, busy_r, load_err_r, err_n;
    logic [IDX_W-1:0] fail_idx_r, fail_n, max_chain_r, max_n;
    logic             box_we_s, pris_we_s, box_ok_s, pris_ok_s, box_full_s, pris_full_s;
    logic [IDX_W-1:0] box_val_s, pris_val_s;

    prison_perm_table #(.N(N), .IDX_W(IDX_W), .KEY(BOX_KEY)) u_boxes (
        .clk(clk), .rst_n(rst_n), .wr_en(box_we_s), .key(guard_key),
        .select(select), .data(data), .wr_ok(box_ok_s), .all_loaded(box_full_s),
        .rd_addr(cur_r), .rd_data(box_val_s)
    );

    prison_perm_table #(.N(N), .IDX_W(IDX_W), .KEY(PRIS_KEY)) u_prisoners (
        .clk(clk), .rst_n(rst_n), .wr_en(pris_we_s), .key(guard_key),
        .select(select), .data(data), .wr_ok(pris_ok_s), .all_loaded(pris_full_s),
        .rd_addr(p_r), .rd_data(pris_val_s)
    );

    // Next-state, counter and result logic.
    always_comb begin
        next_s      = state_r;
        mode_n      = mode_r;
        p_n         = p_r;
        cur_n       = cur_r;
        tries_n     = tries_r;
        win_n       = win_r;
        fail_n      = fail_idx_r;
        max_n       = max_chain_r;
        err_n       = 1'b0;
        box_we_s    = 1'b0;
        pris_we_s   = 1'b0;
        tries_inc_s = tries_r + TRY_ONE;
        case (state_r)
            IDLE: begin
                if (load_boxes && load_prisoners) begin
                    err_n = 1'b1;
                end else if (load_boxes) begin
                    box_we_s = box_ok_s;
                    err_n    = !box_ok_s;
                end else if (load_prisoners) begin
                    pris_we_s = pris_ok_s;
                    err_n     = !pris_ok_s;
                end else begin
                    err_n = 1'b0;
                end
                if (run) begin
                    if (box_full_s && pris_full_s) begin
                        next_s = CHECK;
                    end else begin
                        err_n = 1'b1;
                    end
                end else begin
                    next_s = IDLE;
                end
            end
            CHECK: begin
                win_n  = 1'b0;
                max_n  = {IDX_W{1'b0}};
                p_n    = {IDX_W{1'b0}};
                mode_n = mode_e'(mode);
                next_s = START;
            end
            START: begin
                cur_n   = pris_val_s - ONE;
                tries_n = {TRY_W{1'b0}};
                next_s  = SEARCH;
            end
            SEARCH: begin
                tries_n = tries_inc_s;
                if (box_val_s == pris_val_s) begin
                    if (CW'(tries_inc_s) > CW'(max_chain_r)) begin
                        max_n = IDX_W'(tries_inc_s);
                    end else begin
                        max_n = max_chain_r;
                    end
                    if (p_r == LAST) begin
                        win_n  = 1'b1;
                        fail_n = NVAL;
                        next_s = DONE;
                    end else begin
                        p_n    = p_r + ONE;
                        next_s = START;
                    end
                end else if (tries_inc_s == TRY_LIMIT) begin
                    win_n  = 1'b0;
                    fail_n = p_r;
                    max_n  = MAX_VAL;
                    next_s = DONE;
                end else if (mode_r == MODE_LINEAR) begin
                    cur_n = (cur_r == LAST) ? {IDX_W{1'b0}} : cur_r + ONE;
                end else begin
                    cur_n = box_val_s - ONE;
                end
            end
            DONE: begin
                next_s = IDLE;
            end
            default: begin
                next_s = IDLE;
            end
        endcase
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            mode_r      <= MODE_CYCLE;
            p_r         <= {IDX_W{1'b0}};
            cur_r       <= {IDX_W{1'b0}};
            tries_r     <= {TRY_W{1'b0}};
            win_r       <= 1'b0;
            done_r      <= 1'b0;
            busy_r      <= 1'b0;
            load_err_r  <= 1'b0;
            fail_idx_r  <= {IDX_W{1'b0}};
            max_chain_r <= {IDX_W{1'b0}};
        end else begin
            state_r     <= next_s;
            mode_r      <= mode_n;
            p_r         <= p_n;
            cur_r       <= cur_n;
            tries_r     <= tries_n;
            win_r       <= win_n;
            done_r      <= (next_s == DONE);
            busy_r      <= (next_s == CHECK) || (next_s == START) || (next_s == SEARCH);
            load_err_r  <= err_n;
            fail_idx_r  <= fail_n;
            max_chain_r <= max_n;
        end
    end

    assign busy      = busy_r;
    assign done      = done_r;
    assign win       = win_r;
    assign load_err  = load_err_r;
    assign fail_idx  = fail_idx_r;
    assign max_chain = max_chain_r;

endmodule

// File: tb/tb_prison_cycle_engine.sv
// Bench for prison_cycle_engine: directed N=8 vectors and corner sequences,
// plus random N=100 games against a cycle-length model.
module tb_prison_cycle_engine;

    localparam logic [31:0] BOX_KEY  = 32'hDEADBEEF;
    localparam logic [31:0] PRIS_KEY = 32'hCAFEFACE;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Small instance, N=8, MAX_TRIES=4
    logic       rst_a, lb_a, lp_a, mode_a, run_a;
    logic [3:0] sel_a, data_a;
    logic [31:0] key_a;
    logic       busy_a, done_a, win_a, err_a;
    logic [3:0] fail_a, maxc_a;

    prison_cycle_engine #(.N(8), .MAX_TRIES(4)) dut_a (
        .clk(clk), .rst_n(rst_a), .load_boxes(lb_a), .load_prisoners(lp_a),
        .select(sel_a), .data(data_a), .guard_key(key_a), .mode(mode_a), .run(run_a),
        .busy(busy_a), .done(done_a), .win(win_a), .load_err(err_a),
        .fail_idx(fail_a), .max_chain(maxc_a)
    );

    // Full-size instance, N=100, MAX_TRIES=50
    logic       rst_b, lb_b, lp_b, mode_b, run_b;
    logic [6:0] sel_b, data_b;
    logic [31:0] key_b;
    logic       busy_b, done_b, win_b, err_b;
    logic [6:0] fail_b, maxc_b;

    prison_cycle_engine #(.N(100), .MAX_TRIES(50)) dut_b (
        .clk(clk), .rst_n(rst_b), .load_boxes(lb_b), .load_prisoners(lp_b),
        .select(sel_b), .data(data_b), .guard_key(key_b), .mode(mode_b), .run(run_b),
        .busy(busy_b), .done(done_b), .win(win_b), .load_err(err_b),
        .fail_idx(fail_b), .max_chain(maxc_b)
    );

    typedef logic [7:0][3:0] tab8_t;
    typedef struct packed {
        tab8_t      box;
        tab8_t      pris;
        logic       mode;
        logic       win;
        logic [3:0] fail;
        logic [3:0] maxc;
        logic [7:0] cyc;
    } vec_t;

    vec_t vecs[9];

    function automatic tab8_t pat(input int kind);
        tab8_t t;
        for (int i = 0; i < 8; i++) begin
            case (kind)
                0: t[i] = 4'(i + 1);
                1: t[i] = 4'(((i + 1) % 8) + 1);
                2: t[i] = (i % 4 == 3) ? 4'(i - 2) : 4'(i + 2);
                3: t[i] = (i == 0) ? 4'd8 : 4'(i);
                4: t[i] = 4'(8 - i);
                5: t[i] = (i == 2) ? 4'd1 : ((i == 7) ? 4'd4 : 4'(i + 2));
                default: t[i] = 4'd0;
            endcase
        end
        return t;
    endfunction

    function automatic vec_t mkv(input int b, input int p, input logic m, input logic w,
                                 input int f, input int x, input int c);
        vec_t v;
        v.box  = pat(b);
        v.pris = pat(p);
        v.mode = m;
        v.win  = w;
        v.fail = 4'(f);
        v.maxc = 4'(x);
        v.cyc  = 8'(c);
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic reset_a();
        rst_a = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_a = 1'b1;
    endtask

    task automatic write_a(input logic lb, input logic lp, input int s, input int d,
                           input logic [31:0] k, output logic e);
        lb_a = lb; lp_a = lp; sel_a = 4'(s); data_a = 4'(d); key_a = k;
        @(posedge clk);
        #1 e = err_a;
        lb_a = 1'b0; lp_a = 1'b0;
    endtask

    task automatic load_a(input tab8_t bx, input tab8_t pr, output int errs);
        logic e;
        errs = 0;
        for (int i = 0; i < 8; i++) begin
            write_a(1'b1, 1'b0, i, int'(bx[i]), BOX_KEY, e);
            errs += int'(e);
            write_a(1'b0, 1'b1, i, int'(pr[i]), PRIS_KEY, e);
            errs += int'(e);
        end
    endtask

    task automatic game_a(output int cyc);
        run_a = 1'b1;
        cyc = 0;
        do begin
            @(posedge clk);
            #1 cyc++;
            run_a = 1'b0;
        end while (!done_a && cyc < 200);
    endtask

    task automatic write_b(input logic lb, input logic lp, input int s, input int d,
                           input logic [31:0] k, output logic e);
        lb_b = lb; lp_b = lp; sel_b = 7'(s); data_b = 7'(d); key_b = k;
        @(posedge clk);
        #1 e = err_b;
        lb_b = 1'b0; lp_b = 1'b0;
    endtask

    int bperm[100];
    int pperm[100];
    int clen[100];

    task automatic shuffle_b();
        int j, t;
        for (int i = 0; i < 100; i++) begin
            bperm[i] = i + 1;
            pperm[i] = i + 1;
        end
        for (int i = 99; i > 0; i--) begin
            j = int'($urandom_range(i, 0));
            t = bperm[i]; bperm[i] = bperm[j]; bperm[j] = t;
            j = int'($urandom_range(i, 0));
            t = pperm[i]; pperm[i] = pperm[j]; pperm[j] = t;
        end
    endtask

    task automatic game_b(input int g);
        int  errs, cyc, len, c, win_m, fail_m, max_m, cyc_m, stop;
        logic e;
        rst_b = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_b = 1'b1;
        shuffle_b();
        errs = 0;
        for (int i = 0; i < 100; i++) begin
            write_b(1'b1, 1'b0, i, bperm[i], BOX_KEY, e);
            errs += int'(e);
            write_b(1'b0, 1'b1, i, pperm[i], PRIS_KEY, e);
            errs += int'(e);
        end
        chk($sformatf("b%0d_load_errs", g), errs, 0);
        for (int s = 0; s < 100; s++) begin
            len = 1;
            c = bperm[s] - 1;
            while (c != s) begin
                c = bperm[c] - 1;
                len++;
            end
            clen[s] = len;
        end
        win_m = 1; fail_m = 100; max_m = 0; cyc_m = 1; stop = 0;
        for (int p = 0; p < 100; p++) begin
            if (stop == 0) begin
                len = clen[pperm[p] - 1];
                if (len > 50) begin
                    win_m = 0; fail_m = p; max_m = 50; cyc_m += 51; stop = 1;
                end else begin
                    cyc_m += 1 + len;
                    if (len > max_m) max_m = len;
                end
            end
        end
        cyc_m += 1;
        mode_b = 1'b0;
        run_b = 1'b1;
        cyc = 0;
        do begin
            @(posedge clk);
            #1 cyc++;
            run_b = 1'b0;
        end while (!done_b && cyc < 20000);
        chk($sformatf("b%0d_cycles", g), cyc, cyc_m);
        chk($sformatf("b%0d_win", g), int'(win_b), win_m);
        chk($sformatf("b%0d_fail_idx", g), int'(fail_b), fail_m);
        chk($sformatf("b%0d_max_chain", g), int'(maxc_b), max_m);
    endtask

    initial begin
        int   errs, cyc;
        logic e;

        vecs[0] = mkv(0, 0, 1'b0, 1'b1, 8, 1, 18);
        vecs[1] = mkv(1, 0, 1'b0, 1'b0, 0, 4, 7);
        vecs[2] = mkv(2, 0, 1'b0, 1'b1, 8, 4, 42);
        vecs[3] = mkv(2, 0, 1'b1, 1'b0, 1, 4, 12);
        vecs[4] = mkv(0, 4, 1'b1, 1'b1, 8, 1, 18);
        vecs[5] = mkv(3, 0, 1'b1, 1'b1, 8, 2, 26);
        vecs[6] = mkv(3, 0, 1'b0, 1'b0, 0, 4, 7);
        vecs[7] = mkv(2, 4, 1'b0, 1'b1, 8, 4, 42);
        vecs[8] = mkv(5, 0, 1'b0, 1'b0, 3, 4, 19);

        lb_a = 1'b0; lp_a = 1'b0; sel_a = 4'd0; data_a = 4'd0; key_a = 32'd0;
        mode_a = 1'b0; run_a = 1'b0;
        lb_b = 1'b0; lp_b = 1'b0; sel_b = 7'd0; data_b = 7'd0; key_b = 32'd0;
        mode_b = 1'b0; run_b = 1'b0;
        rst_b = 1'b0;
        reset_a();

        chk("rst_busy", int'(busy_a), 0);
        chk("rst_done", int'(done_a), 0);
        chk("rst_win", int'(win_a), 0);
        chk("rst_load_err", int'(err_a), 0);
        chk("rst_fail_idx", int'(fail_a), 0);
        chk("rst_max_chain", int'(maxc_a), 0);

        // Write validation and value release on rewrite
        write_a(1'b1, 1'b0, 0, 1, 32'd0, e);    chk("bad_key", int'(e), 1);
        @(posedge clk); #1                       chk("err_pulse_len", int'(err_a), 0);
        write_a(1'b1, 1'b0, 0, 3, BOX_KEY, e);  chk("good_write", int'(e), 0);
        write_a(1'b1, 1'b0, 1, 3, BOX_KEY, e);  chk("dup_data", int'(e), 1);
        write_a(1'b1, 1'b0, 8, 1, BOX_KEY, e);  chk("sel_range", int'(e), 1);
        write_a(1'b1, 1'b0, 2, 0, BOX_KEY, e);  chk("data_zero", int'(e), 1);
        write_a(1'b1, 1'b0, 2, 9, BOX_KEY, e);  chk("data_big", int'(e), 1);
        write_a(1'b1, 1'b1, 2, 2, BOX_KEY, e);  chk("both_loads", int'(e), 1);
        write_a(1'b0, 1'b1, 2, 2, BOX_KEY, e);  chk("pris_wrong_key", int'(e), 1);
        write_a(1'b1, 1'b0, 0, 5, BOX_KEY, e);  chk("rewrite_slot", int'(e), 0);
        write_a(1'b1, 1'b0, 1, 3, BOX_KEY, e);  chk("freed_value", int'(e), 0);
        run_a = 1'b1;
        @(posedge clk); #1 run_a = 1'b0;
        chk("run_unloaded_err", int'(err_a), 1);
        chk("run_unloaded_busy", int'(busy_a), 0);

        // Directed game table
        for (int k = 0; k < 9; k++) begin
            reset_a();
            load_a(vecs[k].box, vecs[k].pris, errs);
            chk($sformatf("v%0d_load_errs", k), errs, 0);
            mode_a = vecs[k].mode;
            game_a(cyc);
            chk($sformatf("v%0d_cycles", k), cyc, int'(vecs[k].cyc));
            chk($sformatf("v%0d_win", k), int'(win_a), int'(vecs[k].win));
            chk($sformatf("v%0d_fail_idx", k), int'(fail_a), int'(vecs[k].fail));
            chk($sformatf("v%0d_max_chain", k), int'(maxc_a), int'(vecs[k].maxc));
            @(posedge clk); #1;
            chk($sformatf("v%0d_done_pulse", k), int'(done_a), 0);
            chk($sformatf("v%0d_busy_after", k), int'(busy_a), 0);
        end

        // win is held in IDLE, and a re-run works without reloading
        reset_a();
        load_a(vecs[0].box, vecs[0].pris, errs);
        mode_a = 1'b0;
        game_a(cyc);
        repeat (3) @(posedge clk);
        #1 chk("win_held", int'(win_a), 1);
        game_a(cyc);
        chk("rerun_cycles", cyc, 18);
        chk("rerun_win", int'(win_a), 1);

        // Asynchronous reset in the middle of a search
        reset_a();
        load_a(vecs[2].box, vecs[2].pris, errs);
        mode_a = 1'b0;
        run_a = 1'b1;
        @(posedge clk); #1 run_a = 1'b0;
        repeat (4) @(posedge clk);
        #1 chk("mid_busy_before", int'(busy_a), 1);
        #2 rst_a = 1'b0;
        #1;
        chk("mid_rst_busy", int'(busy_a), 0);
        chk("mid_rst_win", int'(win_a), 0);
        chk("mid_rst_done", int'(done_a), 0);
        repeat (3) @(posedge clk);
        #1 rst_a = 1'b1;
        run_a = 1'b1;
        @(posedge clk); #1 run_a = 1'b0;
        chk("mid_rerun_err", int'(err_a), 1);
        chk("mid_rerun_busy", int'(busy_a), 0);

        for (int g = 0; g < 12; g++) begin
            game_b(g);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
